seven_seg_scan_ctrl: RTL

//  Time-multiplexes one registered 7-seg decoder (val_to_seven_seg) across NUM_DIGITS

---
 rtl/seven_seg_pkg.sv | 35 +++
 rtl/seven_seg_scan_ctrl_scan_timer.sv | 35 +++
 rtl/seven_seg_scan_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_pkg                                                   |
// | Purpose  : Shared constants, scan-FSM state encoding and a small helper    |
// |            function for the seven-segment display path.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

    // Segment-vector width driven by the decoder, and the value width it accepts.
    localparam int SEG_W = 7;
    localparam int VAL_W = 8;

    // Scan FSM state encoding (3 bits).
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DRIVE  = 3'd3;
    localparam logic [2:0] ST_BLANK  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SELECT = ST_SELECT,
        S_SETTLE = ST_SETTLE,
        S_DRIVE  = ST_DRIVE,
        S_BLANK  = ST_BLANK
    } scan_state_t;

    // Larger of two integers, used to size the shared dwell/blank timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_timer                                                      |
// | Purpose  : Loadable down-counter with a done flag. Counts down to zero and |
// |            holds there; a load takes priority over counting.               |
// | Ports    : clk, rst (async, active-high), i_load, i_load_val, o_done       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            // Saturate at zero so the counter never wraps.
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_scan_ctrl                                             |
// | Purpose  : Time-multiplexes one registered 7-seg decoder across NUM_DIGITS |
// |            digits. Holds a per-digit value register file written by host   |
// |            logic, steps SELECT -> SETTLE -> DRIVE -> BLANK per digit and   |
// |            drives the active-low anode of the digit being shown.           |
// | Ports    : clk, reset (async, active-high), enable, wr_en, wr_addr,        |
// |            wr_data -> dec_value, anode_n, digit_idx, frame_tick            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [VAL_W-1:0]              wr_data,
    output logic [VAL_W-1:0]              dec_value,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_TMR_W = $clog2(max_int(DWELL_CYC, BLANK_CYC) + 1);

    // The timer is reloaded with N-1 on entry so that the state lasts N cycles.
    localparam logic [c_TMR_W-1:0] c_DWELL_LOAD = c_TMR_W'(DWELL_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_BLANK_LOAD = c_TMR_W'(BLANK_CYC - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W:0]   c_NUM_EXT    = (c_IDX_W + 1)'(NUM_DIGITS);

    // ------------------------------------------------------------------
    // Value register file
    // ------------------------------------------------------------------
    logic [VAL_W-1:0] r_val [NUM_DIGITS];
    logic             w_wr_ok;

    // Addresses past the last digit exist when NUM_DIGITS is not a power of two.
    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_NUM_EXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_val[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_val[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Dwell / blank timer
    // ------------------------------------------------------------------
    logic               w_tmr_load;
    logic [c_TMR_W-1:0] w_tmr_val;
    logic               w_tmr_done;

    scan_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic                  w_tick_nxt;
    logic                  w_load_dec;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = digit_idx;
        w_tick_nxt  = 1'b0;
        w_load_dec  = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = c_DWELL_LOAD;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SELECT;
                    w_idx_nxt   = '0;
                end
                S_SELECT: begin
                    // Value is captured on the edge leaving SELECT; a write on the
                    // same edge lands in the register file after this read.
                    w_state_nxt = S_SETTLE;
                    w_load_dec  = 1'b1;
                end
                S_SETTLE: begin
                    w_state_nxt = S_DRIVE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_DWELL_LOAD;
                end
                S_DRIVE: begin
                    if (w_tmr_done) begin
                        w_state_nxt = S_BLANK;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_BLANK_LOAD;
                    end
                end
                S_BLANK: begin
                    if (w_tmr_done) begin
                        w_state_nxt = S_SELECT;
                        if (digit_idx == c_LAST_IDX) begin
                            w_idx_nxt  = '0;
                            w_tick_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = digit_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end

        // Anodes are a decode of the next state/index, so the registered output
        // carries no combinational path from any input.
        w_anode_nxt = '1;
        if (w_state_nxt == S_DRIVE) begin
            w_anode_nxt[w_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            digit_idx  <= '0;
            anode_n    <= '1;
            frame_tick <= 1'b0;
            dec_value  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            digit_idx  <= w_idx_nxt;
            anode_n    <= w_anode_nxt;
            frame_tick <= w_tick_nxt;
            if (w_load_dec) begin
                dec_value <= r_val[digit_idx];
            end
        end
    end

endmodule
`default_nettype wire
